// File: rtl/ysyx_25060170_fetch_seq.sv
// Fetch sequencer: owns the architectural PC, issues one instruction-memory request at a time,
// buffers the fetched instruction for decode and squashes wrong-path responses after redirects.
`timescale 1ns/1ps
module ysyx_25060170_fetch_seq #(
    parameter int              PC_W     = 32,
    parameter int              INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_pc_jump,
    input  logic [PC_W-1:0]   id_pc_i,
    input  logic              ie_pc_jump,
    input  logic [PC_W-1:0]   ie_pc_i,
    input  logic              ls_pc_jump,
    input  logic [PC_W-1:0]   ls_pc_i,
    input  logic              id_ready,
    input  logic              id_stall,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    output logic              imem_rsp_ready,
    input  logic [INST_W-1:0] imem_rsp_inst,
    output logic              if_valid,
    output logic [PC_W-1:0]   if_pc,
    output logic [INST_W-1:0] if_inst
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic                discard_q, discard_d;
    logic [PC_W-1:0]     if_pc_q, if_pc_d;
    logic [INST_W-1:0]   if_inst_q, if_inst_d;

    logic                redirect;
    logic [PC_W-1:0]     target;

    // A stalled decode cannot redirect, but later stages always can.
    assign redirect = ls_pc_jump | ie_pc_jump | (id_pc_jump & ~id_stall);
    assign target   = ls_pc_jump ? ls_pc_i : (ie_pc_jump ? ie_pc_i : id_pc_i);

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_q;
    assign imem_rsp_ready = (state_q == WAIT);
    assign if_valid       = (state_q == HOLD) & ~redirect;
    assign if_pc          = if_pc_q;
    assign if_inst        = if_inst_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        if_pc_d   = if_pc_q;
        if_inst_d = if_inst_q;
        case (state_q)
            IDLE: begin
                pc_d    = redirect ? target : pc_q;
                state_d = REQ;
            end
            REQ: begin
                if (imem_req_ready) begin
                    state_d = WAIT;
                end
                // The request already on the bus stays; its response is dropped later.
                if (redirect) begin
                    pc_d      = target;
                    discard_d = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (discard_q | redirect) begin
                        discard_d = 1'b0;
                        pc_d      = redirect ? target : pc_q;
                        state_d   = REQ;
                    end else begin
                        if_inst_d = imem_rsp_inst;
                        if_pc_d   = pc_q;
                        pc_d      = pc_q + PC_W'(4);
                        state_d   = HOLD;
                    end
                end else if (redirect) begin
                    pc_d      = target;
                    discard_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = REQ;
                end else if (id_ready & ~id_stall) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            if_pc_q   <= '0;
            if_inst_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            if_pc_q   <= if_pc_d;
            if_inst_q <= if_inst_d;
        end
    end

endmodule

// File: tb/tb_ysyx_25060170_fetch_seq.sv
// Directed bench for the fetch sequencer: a memory model answers requests, and a monitor
// compares every request address and every decode handoff against scoreboard queues.
`timescale 1ns/1ps
module tb_ysyx_25060170_fetch_seq;

    logic        clk;
    logic        rst;
    logic        id_pc_jump, ie_pc_jump, ls_pc_jump;
    logic [31:0] id_pc_i, ie_pc_i, ls_pc_i;
    logic        id_ready, id_stall;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid, imem_rsp_ready;
    logic [31:0] imem_rsp_inst;
    logic        if_valid;
    logic [31:0] if_pc, if_inst;

    ysyx_25060170_fetch_seq dut (
        .clk(clk), .rst(rst),
        .id_pc_jump(id_pc_jump), .id_pc_i(id_pc_i),
        .ie_pc_jump(ie_pc_jump), .ie_pc_i(ie_pc_i),
        .ls_pc_jump(ls_pc_jump), .ls_pc_i(ls_pc_i),
        .id_ready(id_ready), .id_stall(id_stall),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready),
        .imem_rsp_inst(imem_rsp_inst),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int req_cnt  = 0;
    int handoff_cnt = 0;
    int req_cyc  = 0;
    int rsp_lat  = 0;
    logic mem_ready = 1'b0;
    logic check_lat = 1'b0;
    logic prev_if_valid = 1'b0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_inst_q[$];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h00C0_FFEE;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %h with nothing expected", name, act);
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        exp_addr_q.push_back(pc);
        exp_pc_q.push_back(pc);
        exp_inst_q.push_back(inst_of(pc));
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory model: drives at negedge+1, latches handshakes at negedge+3.
    initial begin
        logic        pending, hs_req, hs_rsp;
        int          cnt;
        logic [31:0] mem_addr, req_addr_lat;
        pending = 1'b0; hs_req = 1'b0; hs_rsp = 1'b0; cnt = 0;
        mem_addr = '0; req_addr_lat = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_inst = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                pending = 1'b0;
                cnt = 0;
            end else if (hs_rsp) begin
                pending = 1'b0;
            end else if (hs_req) begin
                pending  = 1'b1;
                cnt      = rsp_lat;
                mem_addr = req_addr_lat;
            end else if (pending && cnt > 0) begin
                cnt--;
            end
            imem_req_ready = mem_ready;
            imem_rsp_valid = pending && (cnt == 0);
            imem_rsp_inst  = (pending && cnt == 0) ? inst_of(mem_addr) : 32'h0;
            #2;
            hs_req = !rst && imem_req_valid && imem_req_ready;
            hs_rsp = !rst && imem_rsp_valid && imem_rsp_ready;
            if (hs_req) req_addr_lat = imem_req_addr;
        end
    end

    // Monitor: samples at negedge+2 and pops the scoreboard on every handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (imem_req_valid && imem_req_ready) begin
                    req_cnt++;
                    req_cyc = cyc;
                    if (exp_addr_q.size() == 0) report_fail("req_unexpected", imem_req_addr);
                    else check("req_addr", imem_req_addr, exp_addr_q.pop_front());
                end
                if (check_lat && if_valid && !prev_if_valid)
                    check("if_latency", 32'(cyc - req_cyc), 32'd2);
                if (if_valid && id_ready && !id_stall) begin
                    handoff_cnt++;
                    if (exp_pc_q.size() == 0) begin
                        report_fail("handoff_unexpected", if_pc);
                    end else begin
                        check("if_pc", if_pc, exp_pc_q.pop_front());
                        check("if_inst", if_inst, exp_inst_q.pop_front());
                    end
                end
                prev_if_valid = if_valid;
            end else begin
                prev_if_valid = 1'b0;
            end
        end
    end

    task automatic wait_handoffs(input int n);
        int goal;
        goal = handoff_cnt + n;
        for (int i = 0; i < 200 && handoff_cnt < goal; i++) begin
            @(negedge clk);
            #4;
        end
        check("handoff_wait", 32'(handoff_cnt), 32'(goal));
    endtask

    // sel 0 waits for if_valid, sel 1 waits for imem_rsp_ready.
    task automatic wait_sig(input int sel);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            #4;
            seen = (sel == 0) ? if_valid : imem_rsp_ready;
        end
        check(sel == 0 ? "wait_if_valid" : "wait_rsp_ready", 32'(seen), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check({tag, "_rsp_ready"}, 32'(imem_rsp_ready), 32'd0);
        check({tag, "_if_valid"},  32'(if_valid), 32'd0);
        check({tag, "_if_pc"},     if_pc, 32'h0);
        check({tag, "_if_inst"},   if_inst, 32'h0);
        check({tag, "_addr"},      imem_req_addr, 32'h8000_0000);
    endtask

    initial begin
        rst = 1'b1;
        id_pc_jump = 1'b0; ie_pc_jump = 1'b0; ls_pc_jump = 1'b0;
        id_pc_i = '0; ie_pc_i = '0; ls_pc_i = '0;
        id_ready = 1'b0; id_stall = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        check_reset_outputs("reset");

        // T1: zero-wait streaming from the reset PC
        @(negedge clk);
        expect_fetch(32'h8000_0000);
        expect_fetch(32'h8000_0004);
        expect_fetch(32'h8000_0008);
        check_lat = 1'b1;
        id_ready  = 1'b1;
        mem_ready = 1'b1;
        rst       = 1'b0;
        wait_handoffs(3);
        @(negedge clk);
        mem_ready = 1'b0;
        check_lat = 1'b0;
        $display("T1 done: %0d requests, %0d handoffs", req_cnt, handoff_cnt);

        // T2: decode back-pressure holds the buffer
        @(negedge clk);
        expect_fetch(32'h8000_000C);
        id_ready  = 1'b0;
        mem_ready = 1'b1;
        wait_sig(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #4;
            check("t2_if_valid", 32'(if_valid), 32'd1);
            check("t2_if_pc", if_pc, 32'h8000_000C);
            check("t2_if_inst", if_inst, inst_of(32'h8000_000C));
            check("t2_no_req", 32'(imem_req_valid), 32'd0);
        end
        @(negedge clk);
        id_ready  = 1'b1;
        mem_ready = 1'b0;
        wait_handoffs(1);
        $display("T2 done: if_pc held for 5 cycles");

        // T3: execute redirect while waiting; late response must be dropped
        @(negedge clk);
        exp_addr_q.push_back(32'h8000_0010);
        expect_fetch(32'h8000_0100);
        rsp_lat   = 3;
        mem_ready = 1'b1;
        wait_sig(1);
        @(negedge clk);
        ie_pc_jump = 1'b1;
        ie_pc_i    = 32'h8000_0100;
        #4;
        check("t3_if_valid_c0", 32'(if_valid), 32'd0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            ie_pc_jump = 1'b0;
            rsp_lat    = 0;
            #4;
            check("t3_if_valid", 32'(if_valid), 32'd0);
        end
        wait_handoffs(1);
        @(negedge clk);
        mem_ready = 1'b0;
        $display("T3 done: next fetch from %h", 32'h8000_0100);

        // T4: ls and ie redirect together in HOLD; ls wins
        @(negedge clk);
        exp_addr_q.push_back(32'h8000_0104);
        expect_fetch(32'h8000_0200);
        id_ready  = 1'b0;
        mem_ready = 1'b1;
        wait_sig(0);
        @(negedge clk);
        ls_pc_jump = 1'b1; ls_pc_i = 32'h8000_0200;
        ie_pc_jump = 1'b1; ie_pc_i = 32'h8000_0300;
        #4;
        check("t4_if_valid_kill", 32'(if_valid), 32'd0);
        check("t4_no_req", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        ls_pc_jump = 1'b0;
        ie_pc_jump = 1'b0;
        id_ready   = 1'b1;
        wait_handoffs(1);
        @(negedge clk);
        mem_ready = 1'b0;
        $display("T4 done: ls target taken");

        // T5: stalled decode redirect is ignored
        @(negedge clk);
        expect_fetch(32'h8000_0204);
        id_pc_jump = 1'b1;
        id_pc_i    = 32'h8000_0400;
        id_stall   = 1'b1;
        mem_ready  = 1'b1;
        wait_sig(0);
        check("t5_if_pc", if_pc, 32'h8000_0204);
        @(negedge clk);
        id_pc_jump = 1'b0;
        id_stall   = 1'b0;
        mem_ready  = 1'b0;
        wait_handoffs(1);
        $display("T5 done: stalled id redirect ignored");

        // T6: reset while a response is outstanding
        @(negedge clk);
        exp_addr_q.push_back(32'h8000_0208);
        rsp_lat   = 20;
        mem_ready = 1'b1;
        wait_sig(1);
        @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #4;
            check("t6_still_wait", 32'(imem_rsp_ready), 32'd1);
        end
        @(negedge clk);
        rst = 1'b1;
        #4;
        check_reset_outputs("t6_reset");
        @(negedge clk);
        expect_fetch(32'h8000_0000);
        rsp_lat   = 0;
        mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_handoffs(1);
        @(negedge clk);
        mem_ready = 1'b0;
        $display("T6 done: restart from reset PC");

        repeat (4) @(negedge clk);
        check("sb_addr_left", 32'(exp_addr_q.size()), 32'd0);
        check("sb_if_left", 32'(exp_pc_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
